// File: rtl/rans_ctrl_regs.sv
// AXI-lite control/status register block for the rANS core: start/irq control,
// source/destination/length programming, busy/done/out_len status and an ID word.
module rans_ctrl_regs #(
    parameter logic [31:0] ID_VALUE = 32'h52414E53
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic        start_o,
    output logic [31:0] src_addr_o,
    output logic [31:0] dst_addr_o,
    output logic [31:0] length_o,
    output logic        irq_o,
    input  logic        busy_i,
    input  logic        done_i,
    input  logic [31:0] out_len_i
);

    typedef enum logic [5:0] {
        REG_CTRL    = 6'd0,
        REG_STATUS  = 6'd1,
        REG_SRC     = 6'd2,
        REG_DST     = 6'd3,
        REG_LENGTH  = 6'd4,
        REG_OUT_LEN = 6'd5,
        REG_ID      = 6'd6
    } reg_idx_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic        aw_held;
    logic [5:0]  aw_idx;
    logic        w_held;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        irq_en;
    logic        done;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] length;
    logic        do_write;
    logic        w1c_done;
    logic [31:0] rdata_nxt;
    logic [1:0]  rresp_nxt;
    logic        addr_unused;

    // Only addr[7:2] selects a register; the remaining address bits are don't-care.
    assign addr_unused = ^{awaddr[31:8], awaddr[1:0], araddr[31:8], araddr[1:0]};

    assign awready  = ~rst_i & ~aw_held & ~bvalid;
    assign wready   = ~rst_i & ~w_held & ~bvalid;
    assign arready  = ~rst_i & ~rvalid;
    assign do_write = aw_held & w_held;
    assign w1c_done = do_write & (aw_idx == REG_STATUS) & w_strb[0] & w_data[1];

    assign src_addr_o = src_addr;
    assign dst_addr_o = dst_addr;
    assign length_o   = length;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        byte_merge = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) begin
                byte_merge[8*i +: 8] = new_val[8*i +: 8];
            end
        end
    endfunction

    always_comb begin
        rdata_nxt = '0;
        rresp_nxt = RESP_OKAY;
        case (araddr[7:2])
            REG_CTRL:    rdata_nxt = {30'd0, irq_en, 1'b0};
            REG_STATUS:  rdata_nxt = {30'd0, done, busy_i};
            REG_SRC:     rdata_nxt = src_addr;
            REG_DST:     rdata_nxt = dst_addr;
            REG_LENGTH:  rdata_nxt = length;
            REG_OUT_LEN: rdata_nxt = out_len_i;
            REG_ID:      rdata_nxt = ID_VALUE;
            default:     rresp_nxt = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_held  <= 1'b0;
            aw_idx   <= '0;
            w_held   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid   <= 1'b0;
            bresp    <= '0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= '0;
            irq_en   <= 1'b0;
            done     <= 1'b0;
            src_addr <= '0;
            dst_addr <= '0;
            length   <= '0;
            start_o  <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            start_o <= 1'b0;
            irq_o   <= done & irq_en;
            // A done pulse wins over a simultaneous W1C so no completion is lost.
            done    <= done_i | (done & ~w1c_done);

            if (awvalid && awready) begin
                aw_held <= 1'b1;
                aw_idx  <= awaddr[7:2];
            end
            if (wvalid && wready) begin
                w_held <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
            end

            if (do_write) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= (aw_idx <= REG_ID) ? RESP_OKAY : RESP_SLVERR;
                case (aw_idx)
                    REG_CTRL: begin
                        if (w_strb[0]) begin
                            irq_en  <= w_data[1];
                            start_o <= w_data[0] & ~busy_i;
                        end
                    end
                    REG_SRC:    src_addr <= byte_merge(src_addr, w_data, w_strb);
                    REG_DST:    dst_addr <= byte_merge(dst_addr, w_data, w_strb);
                    REG_LENGTH: length   <= byte_merge(length, w_data, w_strb);
                    default: ;
                endcase
            end

            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= rdata_nxt;
                rresp  <= rresp_nxt;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rans_ctrl_regs.sv
// Self-checking bench for rans_ctrl_regs: directed register-map scenarios plus
// randomized AXI-lite traffic checked against a transaction-level register model.
module tb_rans_ctrl_regs;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        start_o;
    logic [31:0] src_addr_o;
    logic [31:0] dst_addr_o;
    logic [31:0] length_o;
    logic        irq_o;
    logic        busy_i = 1'b0;
    logic        done_i = 1'b0;
    logic [31:0] out_len_i = '0;

    rans_ctrl_regs #(.ID_VALUE(32'h52414E53)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .start_o(start_o), .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o),
        .length_o(length_o), .irq_o(irq_o),
        .busy_i(busy_i), .done_i(done_i), .out_len_i(out_len_i)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned start_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Register model: architectural state only, updated once per accepted write.
    logic        m_irq_en = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_src = '0, m_dst = '0, m_len = '0;
    logic [31:0] pend_addr = '0, pend_data = '0;
    logic [3:0]  pend_strb = '0;
    logic        s_done = 1'b0, s_busy = 1'b0, s_rst = 1'b1;
    logic        bvalid_prev = 1'b0;
    bit          rand_done = 1'b0;
    logic        done_force = 1'b0;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    function automatic void model_read(input logic [31:0] addr, output logic [31:0] d,
                                       output logic [1:0] r);
        int unsigned off;
        off = {24'd0, addr[7:0]} & 32'hFC;
        r = 2'b00;
        case (off)
            32'h00: d = {30'd0, m_irq_en, 1'b0};
            32'h04: d = {30'd0, m_done, busy_i};
            32'h08: d = m_src;
            32'h0C: d = m_dst;
            32'h10: d = m_len;
            32'h14: d = out_len_i;
            32'h18: d = 32'h52414E53;
            default: begin d = 32'd0; r = 2'b10; end
        endcase
    endfunction

    always @(posedge clk_i) begin
        s_done = done_i;
        s_busy = busy_i;
        s_rst  = rst_i;
    end

    always @(posedge clk_i) begin
        #2;
        done_i = rand_done ? ($urandom_range(0, 9) == 0) : done_force;
    end

    always @(negedge clk_i) if (start_o) start_cnt++;

    // Per-cycle compare: model advanced by one clock edge, then outputs checked.
    always @(negedge clk_i) begin
        logic       exp_irq, exp_start, w1c;
        int unsigned off;
        exp_irq   = m_done & m_irq_en;
        exp_start = 1'b0;
        w1c       = 1'b0;
        if (s_rst) begin
            m_irq_en = 1'b0; m_done = 1'b0;
            m_src = '0; m_dst = '0; m_len = '0;
            exp_irq = 1'b0;
        end else begin
            if (bvalid && !bvalid_prev) begin
                off = {24'd0, pend_addr[7:0]} & 32'hFC;
                check("bresp", {30'd0, bresp}, (off < 32'h1C) ? 32'd0 : 32'd2);
                case (off)
                    32'h00: if (pend_strb[0]) begin
                        m_irq_en  = pend_data[1];
                        exp_start = pend_data[0] & ~s_busy;
                    end
                    32'h04: w1c = pend_strb[0] & pend_data[1];
                    32'h08: m_src = apply_strb(m_src, pend_data, pend_strb);
                    32'h0C: m_dst = apply_strb(m_dst, pend_data, pend_strb);
                    32'h10: m_len = apply_strb(m_len, pend_data, pend_strb);
                    default: ;
                endcase
            end
            m_done = s_done | (m_done & ~w1c);
        end
        bvalid_prev = bvalid;
        check("start_o", start_o, exp_start);
        check("irq_o", irq_o, exp_irq);
        check("src_addr_o", src_addr_o, m_src);
        check("dst_addr_o", dst_addr_o, m_dst);
        check("length_o", length_o, m_len);
        check("arready", arready, !rvalid && !rst_i);
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int mode, input int gap, input int hold, input bit done_at_apply,
                             output logic [1:0] resp);
        bit aw_done, w_done;
        int cnt, t, lat;
        aw_done = 0; w_done = 0; cnt = 0; t = 0;
        pend_addr = addr; pend_data = data; pend_strb = strb;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = (mode != 2);
        wvalid  = (mode != 1);
        while (!(aw_done && w_done) && t < 40) begin
            @(posedge clk_i); t++;
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            #1;
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
            if (aw_done != w_done && !awvalid && !wvalid) begin
                if (cnt >= gap) begin
                    if (!aw_done) awvalid = 1'b1; else wvalid = 1'b1;
                end else cnt++;
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("aw_w_handshake", {31'd0, aw_done && w_done}, 32'd1);
        check("bvalid_early", bvalid, 1'b0);
        if (done_at_apply) done_force = 1'b1;
        lat = 0;
        do begin
            @(posedge clk_i); lat++; #1; done_force = 1'b0;
        end while (!bvalid && lat < 20);
        check("b_latency", lat, 32'd1);
        resp = bresp;
        for (int i = 0; i < hold; i++) begin
            check("b_hold_bvalid", bvalid, 1'b1);
            check("b_hold_bresp", bresp, resp);
            check("b_hold_ready", {awready, wready}, 2'b00);
            @(posedge clk_i); #1;
        end
        bready = 1'b1;
        @(posedge clk_i); #1;
        bready = 1'b0;
        check("b_done", bvalid, 1'b0);
        check("aw_w_resume", {awready, wready}, 2'b11);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hold,
                            output logic [31:0] data, output logic [1:0] resp);
        bit hs;
        int t;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        hs = 0; t = 0; exp_d = '0; exp_r = '0;
        araddr = addr; arvalid = 1'b1;
        do begin
            @(posedge clk_i); t++;
            hs = arready;
            if (hs) model_read(addr, exp_d, exp_r);
            #1;
        end while (!hs && t < 20);
        arvalid = 1'b0;
        check("ar_handshake", {31'd0, hs}, 32'd1);
        check("r_latency", rvalid, 1'b1);
        data = rdata;
        resp = rresp;
        for (int i = 0; i < hold; i++) begin
            check("r_hold_rvalid", rvalid, 1'b1);
            check("r_hold_rdata", rdata, data);
            check("r_hold_arready", arready, 1'b0);
            @(posedge clk_i); #1;
        end
        rready = 1'b1;
        @(posedge clk_i); #1;
        rready = 1'b0;
        check("r_done", rvalid, 1'b0);
        check("rdata", data, exp_d);
        check("rresp", resp, exp_r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr, br;
        logic [31:0] a;
        int unsigned sc;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ready", {awready, wready, arready}, 3'b000);
        check("rst_valid", {bvalid, rvalid, start_o, irq_o}, 4'b0000);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1;
        check("post_rst_ready", {awready, wready, arready}, 3'b111);
        @(posedge clk_i); #1;

        // Address phase leads data phase by two cycles.
        axi_write(32'h08, 32'h1000_0000, 4'hF, 1, 2, 0, 0, br);
        check("src_bresp", br, 2'b00);
        axi_read(32'h08, 0, rd, rr);
        check("src_read", rd, 32'h1000_0000);

        axi_write(32'h10, 32'h0, 4'hF, 0, 0, 0, 0, br);
        axi_write(32'h10, 32'hAABBCCDD, 4'h5, 2, 1, 0, 0, br);
        axi_read(32'h10, 0, rd, rr);
        check("len_strobe", rd, 32'h00BB00DD);

        busy_i = 1'b0;
        sc = start_cnt;
        axi_write(32'h00, 32'h3, 4'h1, 0, 0, 0, 0, br);
        repeat (3) @(posedge clk_i); #1;
        check("start_pulses", start_cnt - sc, 32'd1);
        busy_i = 1'b1;
        sc = start_cnt;
        axi_write(32'h00, 32'h3, 4'hF, 0, 0, 0, 0, br);
        repeat (3) @(posedge clk_i); #1;
        check("start_busy", start_cnt - sc, 32'd0);
        check("start_busy_bresp", br, 2'b00);
        axi_read(32'h00, 0, rd, rr);
        check("ctrl_read", rd, 32'h2);

        busy_i = 1'b0;
        done_force = 1'b1;
        @(posedge clk_i); #1;
        done_force = 1'b0;
        repeat (3) @(posedge clk_i); #1;
        check("irq_set", irq_o, 1'b1);
        axi_read(32'h04, 0, rd, rr);
        check("status_done", rd, 32'h2);
        axi_write(32'h04, 32'h2, 4'h1, 0, 0, 0, 1, br);
        axi_read(32'h04, 0, rd, rr);
        check("done_vs_w1c", rd, 32'h2);
        axi_write(32'h04, 32'h2, 4'h1, 1, 1, 0, 0, br);
        axi_read(32'h04, 0, rd, rr);
        check("done_cleared", rd, 32'h0);
        repeat (2) @(posedge clk_i); #1;
        check("irq_cleared", irq_o, 1'b0);

        axi_read(32'h20, 0, rd, rr);
        check("unmapped_rdata", rd, 32'h0);
        check("unmapped_rresp", rr, 2'b10);
        axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0, br);
        check("unmapped_bresp", br, 2'b10);
        axi_read(32'h08, 0, rd, rr);
        check("unmapped_nochange", rd, 32'h1000_0000);
        axi_read(32'hFFFF_FF1B, 0, rd, rr);
        check("id_read", rd, 32'h52414E53);

        axi_write(32'h0C, 32'hDEAD_BEEF, 4'hF, 0, 0, 5, 0, br);
        axi_read(32'h0C, 5, rd, rr);
        check("dst_read", rd, 32'hDEAD_BEEF);

        rand_done = 1'b1;
        for (int i = 0; i < 200; i++) begin
            int unsigned idx;
            busy_i    = 1'($urandom_range(0, 1));
            out_len_i = $urandom;
            idx = $urandom_range(0, 9);
            a = $urandom;
            a[7:2] = idx[5:0];
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0, br);
            else
                axi_read(a, int'($urandom_range(0, 2)), rd, rr);
        end
        rand_done = 1'b0;
        busy_i = 1'b0;
        @(posedge clk_i); #1;

        // Reset lands while both a write response and a read response are pending.
        pend_addr = 32'h08; pend_data = 32'h1234_5678; pend_strb = 4'hF;
        awaddr = 32'h08; wdata = 32'h1234_5678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h18; arvalid = 1'b1;
        @(posedge clk_i); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        repeat (2) @(posedge clk_i); #1;
        check("pre_rst_pending", {bvalid, rvalid}, 2'b11);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("mid_rst_valid", {bvalid, rvalid, start_o, irq_o}, 4'b0000);
        check("mid_rst_ready", {awready, wready, arready}, 3'b000);
        check("mid_rst_resp", {bresp, rresp}, 4'b0000);
        check("mid_rst_rdata", rdata, 32'h0);
        check("mid_rst_regs", src_addr_o | dst_addr_o | length_o, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1;
        check("post_rst2_ready", {awready, wready, arready}, 3'b111);
        axi_read(32'h08, 0, rd, rr);
        check("post_rst_src", rd, 32'h0);

        repeat (2) @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
